// File: rtl/mux_4_1_rr_arbiter.sv
// rtl/mux_4_1_rr_arbiter.sv - round-robin 4:1 arbiter with one-entry registered output
//
// Shares one 4:1 mux among four valid/ready requesters and registers the
// selected word for a single downstream sink.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_vld    per-requester valid
//   req_data0..req_data3  per-requester words
//   req_rdy    per-requester take strobe (one-hot or zero, combinational)
//   out_vld    output register holds a word
//   out_data   registered selected word
//   out_src    index of the requester that supplied out_data
//   out_rdy    sink accepts out_data this cycle
module mux_4_1_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_vld,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_rdy
);

    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;
    logic             load;
    logic             grant;
    logic [WIDTH-1:0] sel_data;

    // The output register can take a new word when empty or being drained.
    assign load  = ~out_vld | out_rdy;
    // rst gates the grant so req_rdy is zero throughout reset.
    assign grant = load & (|req_vld) & ~rst;

    // Search ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps mod 4.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req_vld[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        req_rdy = 4'b0000;
        if (grant) begin
            req_rdy[winner] = 1'b1;
        end
    end

    always_comb begin
        case (winner)
            2'd0:    sel_data = req_data0;
            2'd1:    sel_data = req_data1;
            2'd2:    sel_data = req_data2;
            default: sel_data = req_data3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_src  <= 2'd0;
            ptr      <= 2'd0;
        end else if (grant) begin
            out_vld  <= 1'b1;
            out_data <= sel_data;
            out_src  <= winner;
            ptr      <= winner + 2'd1;
        end else if (load) begin
            // Drained (or already empty) with nothing pending; data, source and pointer hold.
            out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb/tb_mux_4_1_rr_arbiter.sv - self-checking bench for mux_4_1_rr_arbiter
module tb_mux_4_1_rr_arbiter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       req_vld;
    logic [WIDTH-1:0] req_data [4];
    logic [3:0]       req_rdy;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_src;
    logic             out_rdy;

    mux_4_1_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_data0 (req_data[0]),
        .req_data1 (req_data[1]),
        .req_data2 (req_data[2]),
        .req_data3 (req_data[3]),
        .req_rdy   (req_rdy),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_rdy   (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: priority kept as an ordered list of requester indices.
    int               order[$];
    logic             m_vld;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       m_src;
    logic [3:0]       rdy_seen;
    int               taken;
    int               delivered;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        order  = {0, 1, 2, 3};
        m_vld  = 1'b0;
        m_data = '0;
        m_src  = 2'd0;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic tick();
        logic       m_load;
        int         w;
        logic [3:0] exp_rdy;
        #1;
        m_load  = !m_vld || out_rdy;
        w       = -1;
        foreach (order[j]) begin
            if (w < 0 && req_vld[order[j]]) w = order[j];
        end
        exp_rdy = (m_load && w >= 0) ? (4'b0001 << w) : 4'b0000;
        check_val("req_rdy", req_rdy, exp_rdy);
        check_val("onehot", $countones(req_rdy) <= 1, 1);
        check_val("out_vld", out_vld, m_vld);
        check_val("out_data", out_data, m_data);
        check_val("out_src", out_src, m_src);
        rdy_seen = req_rdy;
        if ((req_rdy & req_vld) != 0) taken++;
        if (out_vld && out_rdy) delivered++;
        @(posedge clk);
        if (exp_rdy != 0) begin
            m_vld  = 1'b1;
            m_data = req_data[w];
            m_src  = 2'(w);
            while (order[$] != w) order.push_back(order.pop_front());
        end else if (m_load) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req_vld = 4'b0000;
        out_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [3:0] pend;

    initial begin
        rst     = 1'b0;
        req_vld = 4'b0000;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = '0;
        taken     = 0;
        delivered = 0;
        @(negedge clk);
        do_reset();
        tick();

        // All four requesting with full drain: strict rotation, no bubbles.
        req_data[0] = 4'hA; req_data[1] = 4'hB; req_data[2] = 4'hC; req_data[3] = 4'hD;
        req_vld = 4'b1111;
        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_val("rr_src", out_src, k % 4);
            check_val("rr_data", out_data, 4'hA + k % 4);
            check_val("rr_vld", out_vld, 1);
        end

        // Asynchronous reset mid-transfer with a held word.
        rst = 1'b1;
        #1;
        check_val("rst_out_vld", out_vld, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_src", out_src, 0);
        check_val("rst_req_rdy", req_rdy, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        req_vld = 4'b1010;
        tick();
        check_val("rst_restart_src", out_src, 1);

        // Backpressure with requesters 0 and 2.
        do_reset();
        req_vld = 4'b0101;
        req_data[0] = 4'h3; req_data[2] = 4'h7;
        tick();
        check_val("bp_first_src", out_src, 0);
        req_vld = 4'b0100;
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("bp_hold_src", out_src, 0);
            check_val("bp_hold_data", out_data, 4'h3);
        end
        out_rdy = 1'b1;
        #1;
        check_val("bp_release_rdy", req_rdy, 4'b0100);
        tick();
        check_val("bp_second_src", out_src, 2);

        // Pointer wrap and skip.
        do_reset();
        req_vld = 4'b1000;
        tick();
        check_val("wrap_src3", out_src, 3);
        req_vld = 4'b1010;
        tick();
        check_val("skip_src1", out_src, 1);
        req_vld = 4'b1000;
        tick();
        check_val("skip_src3", out_src, 3);

        // Drain to empty; pointer must stay parked after requester 2.
        do_reset();
        req_vld = 4'b0100;
        req_data[2] = 4'h9;
        check_val("drain_pre_vld", out_vld, 0);
        tick();
        check_val("drain_rise_vld", out_vld, 1);
        req_vld = 4'b0000;
        tick();
        check_val("drain_fall_vld", out_vld, 0);
        for (int k = 0; k < 3; k++) tick();
        req_vld = 4'b1111;
        #1;
        check_val("drain_ptr3_rdy", req_rdy, 4'b1000);
        tick();
        req_vld = 4'b0000;
        tick();
        tick();

        // Random traffic against the model plus a word-conservation scoreboard.
        do_reset();
        taken     = 0;
        delivered = 0;
        pend      = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]     = 1'b1;
                    req_data[i] = WIDTH'($urandom);
                end
            end
            req_vld = pend;
            out_rdy = ($urandom_range(0, 3) != 0);
            tick();
            pend = pend & ~rdy_seen;
        end
        #1;
        check_val("conserve", taken, delivered + int'(out_vld));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
